// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-of-N decoder with valid/ready input, out-of-range flag,
// selectable output polarity and an autonomous scan mode with blanking between positions.
module dec_onehot_seq #(
  parameter int unsigned IN_W       = 4,
  parameter int unsigned OUT_N      = 10,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned SCAN_DIV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a_in,
  output logic [OUT_N-1:0]  b_out,
  output logic              out_valid,
  output logic              err
);

  localparam int unsigned IdxW = $clog2(OUT_N);
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [OUT_N-1:0] Inact   = ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};
  localparam logic [OUT_N-1:0] One     = {{(OUT_N-1){1'b0}}, 1'b1};
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(OUT_N - 1);
  localparam logic [DivW-1:0]  DivLast = DivW'(SCAN_DIV - 1);
  // One bit wider than a_in so OUT_N == 2**IN_W still compares correctly.
  localparam logic [IN_W:0]    CodeLim = (IN_W + 1)'(OUT_N);

  localparam logic [1:0] StDirect    = 2'd0;
  localparam logic [1:0] StScanOn    = 2'd1;
  localparam logic [1:0] StScanBlank = 2'd2;
  localparam logic [1:0] StSwitch    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d, idx_next;
  logic [DivW-1:0]  div_q, div_d;
  logic [OUT_N-1:0] b_out_d;
  logic             err_d, out_valid_d;
  logic             scan_class, go_switch;

  assign in_ready   = (state_q == StDirect);
  assign scan_class = (state_q == StScanOn) || (state_q == StScanBlank);
  // SWITCH itself resolves the requested mode on exit, so it never re-enters itself.
  assign go_switch  = (state_q != StSwitch) && (mode != scan_class);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    b_out_d     = b_out;
    err_d       = err;
    out_valid_d = 1'b0;
    idx_next    = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

    case (state_q)
      StDirect: begin
        if (in_valid) begin
          if ({1'b0, a_in} < CodeLim) begin
            b_out_d     = Inact ^ (One << a_in);
            err_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            b_out_d = Inact;
            err_d   = 1'b1;
          end
        end
      end
      StScanOn: begin
        if (div_q == DivLast) begin
          state_d = StScanBlank;
          b_out_d = Inact;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StScanBlank: begin
        state_d     = StScanOn;
        idx_d       = idx_next;
        div_d       = '0;
        b_out_d     = Inact ^ (One << idx_next);
        out_valid_d = 1'b1;
      end
      StSwitch: begin
        idx_d = '0;
        div_d = '0;
        if (mode) begin
          state_d     = StScanOn;
          b_out_d     = Inact ^ One;
          out_valid_d = 1'b1;
        end else begin
          state_d = StDirect;
        end
      end
      default: state_d = StDirect;
    endcase

    if (go_switch) begin
      state_d     = StSwitch;
      b_out_d     = Inact;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      idx_d       = '0;
      div_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StDirect;
      idx_q     <= '0;
      div_q     <= '0;
      b_out     <= Inact;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      b_out     <= b_out_d;
      err       <= err_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Scoreboard bench for dec_onehot_seq: default instance plus an 8-output active-high instance.
module tb_dec_onehot_seq;

  logic       clk = 1'b0;
  logic       rst, mode, in_valid;
  logic [3:0] a_in;
  logic       in_ready, out_valid, err;
  logic [9:0] b_out;

  logic       b_in_valid;
  logic [2:0] b_a_in;
  logic       b_in_ready, b_out_valid, b_err;
  logic [7:0] b_b_out;

  int checks = 0;
  int errors = 0;

  // Expected {err, b_out} for each out_valid pulse of the default instance.
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  dec_onehot_seq dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_out    (b_out),
    .out_valid(out_valid),
    .err      (err)
  );

  dec_onehot_seq #(
    .IN_W      (3),
    .OUT_N     (8),
    .ACTIVE_LOW(1'b0),
    .SCAN_DIV  (4)
  ) dut_hi (
    .clk      (clk),
    .rst      (rst),
    .mode     (1'b0),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .a_in     (b_a_in),
    .b_out    (b_b_out),
    .out_valid(b_out_valid),
    .err      (b_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] sel_lo(input int k);
    logic [9:0] one;
    one = 10'd1;
    return ~(one << k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got b_out=%0h err=%0b expected no pulse", b_out, err);
      end else begin
        logic [10:0] e;
        e = sb_q.pop_front();
        chk("sb_pulse", {21'd0, err, b_out}, {21'd0, e});
      end
    end
  end

  initial begin
    logic [9:0] eb;
    logic       eov;
    int         p, idx;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; a_in = '0;
    b_in_valid = 1'b0; b_a_in = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_b_out", b_out, 10'h3ff);
    chk("rst_err", err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("hi_rst_b_out", b_b_out, 8'h00);

    // Active-high 8-output instance.
    step(); b_in_valid = 1'b1; b_a_in = 3'd7;
    step(); b_a_in = 3'd2;
    @(negedge clk);
    chk("hi_code7", b_b_out, 8'b1000_0000);
    step(); b_in_valid = 1'b0;
    @(negedge clk);
    chk("hi_code2", b_b_out, 8'b0000_0100);
    chk("hi_err", b_err, 0);

    // Single decode then hold.
    step(); in_valid = 1'b1; a_in = 4'd3; sb_q.push_back({1'b0, 10'b1111110111});
    step(); in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("hold_b_out", b_out, 10'b1111110111);
    chk("hold_out_valid", out_valid, 0);

    // Out-of-range then recovery.
    step(); in_valid = 1'b1; a_in = 4'd12;
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("oor_b_out", b_out, 10'h3ff);
    chk("oor_err", err, 1);
    chk("oor_out_valid", out_valid, 0);
    step(); in_valid = 1'b1; a_in = 4'd0; sb_q.push_back({1'b0, 10'b1111111110});
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("recover_err", err, 0);

    // Back-to-back streaming 0..9.
    for (int i = 0; i < 10; i++) begin
      step(); in_valid = 1'b1; a_in = 4'(i); sb_q.push_back({1'b0, sel_lo(i)});
      if (i > 0) begin
        @(negedge clk);
        chk("stream_out_valid", out_valid, 1);
      end
    end
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_b_out", b_out, sel_lo(9));
    step();
    @(negedge clk);
    chk("stream_end_valid", out_valid, 0);
    chk("stream_sb_drained", sb_q.size(), 0);

    // Scan sweep with a code presented concurrently; it must be ignored.
    step(); mode = 1'b1; in_valid = 1'b1; a_in = 4'd5;
    for (int k = 0; k < 17; k++) sb_q.push_back({1'b0, sel_lo(k % 10)});
    for (int c = 0; c < 83; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) begin
        eb = 10'h3ff; eov = 1'b0;
      end else begin
        p   = (c - 1) % 5;
        idx = ((c - 1) / 5) % 10;
        eb  = (p == 4) ? 10'h3ff : sel_lo(idx);
        eov = (p == 0);
      end
      chk("scan_b_out", b_out, eb);
      chk("scan_out_valid", out_valid, eov);
      chk("scan_in_ready", in_ready, 0);
      chk("scan_err", err, 0);
    end

    // Reset while index 6 is active.
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_b_out", b_out, 10'h3ff);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_sb_drained", sb_q.size(), 0);
    rst = 1'b0;

    // Mode glitch 0->1->0: one blank cycle, then straight back to direct.
    step(); mode = 1'b1;
    step(); mode = 1'b0;
    @(negedge clk);
    chk("glitch_switch_ready", in_ready, 0);
    chk("glitch_switch_b_out", b_out, 10'h3ff);
    @(negedge clk);
    chk("glitch_direct_ready", in_ready, 1);
    chk("glitch_direct_b_out", b_out, 10'h3ff);
    chk("glitch_direct_valid", out_valid, 0);
    repeat (4) @(negedge clk);
    chk("glitch_no_scan_b_out", b_out, 10'h3ff);
    chk("final_sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
